// File: rtl/ball_pkg.sv
// Shared types and default thresholds for the ball color run detector.
package ball_pkg;

    typedef enum logic [2:0] {
        VOID   = 3'd0,
        RED    = 3'd1,
        BLUE   = 3'd2,
        YELLOW = 3'd3,
        BLACK  = 3'd4
    } color_class_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2
    } run_state_e;

    localparam int DEF_MIN_SAT     = 6;
    localparam int DEF_MIN_VAL     = 6;
    localparam int DEF_BLACK_VAL   = 4;
    localparam int DEF_RED_HIGH    = 20;
    localparam int DEF_RED_LOW     = 340;
    localparam int DEF_BLUE_LOW    = 200;
    localparam int DEF_BLUE_HIGH   = 250;
    localparam int DEF_YELLOW_LOW  = 45;
    localparam int DEF_YELLOW_HIGH = 70;

endpackage

// File: rtl/ball_pixel_class.sv
// Combinational HSV pixel classifier: RED / BLUE / YELLOW / BLACK / VOID.
module ball_pixel_class
    import ball_pkg::*;
#(
    parameter int MIN_SAT     = DEF_MIN_SAT,
    parameter int MIN_VAL     = DEF_MIN_VAL,
    parameter int BLACK_VAL   = DEF_BLACK_VAL,
    parameter int RED_HIGH    = DEF_RED_HIGH,
    parameter int RED_LOW     = DEF_RED_LOW,
    parameter int BLUE_LOW    = DEF_BLUE_LOW,
    parameter int BLUE_HIGH   = DEF_BLUE_HIGH,
    parameter int YELLOW_LOW  = DEF_YELLOW_LOW,
    parameter int YELLOW_HIGH = DEF_YELLOW_HIGH
)(
    input  logic [8:0]   hue,
    input  logic [4:0]   saturation,
    input  logic [4:0]   value,
    output color_class_e pixel_class
);

    localparam logic [8:0] RED_HIGH_H    = 9'(RED_HIGH);
    localparam logic [8:0] RED_LOW_H     = 9'(RED_LOW);
    localparam logic [8:0] BLUE_LOW_H    = 9'(BLUE_LOW);
    localparam logic [8:0] BLUE_HIGH_H   = 9'(BLUE_HIGH);
    localparam logic [8:0] YELLOW_LOW_H  = 9'(YELLOW_LOW);
    localparam logic [8:0] YELLOW_HIGH_H = 9'(YELLOW_HIGH);
    localparam logic [4:0] MIN_SAT_S     = 5'(MIN_SAT);
    localparam logic [4:0] MIN_VAL_V     = 5'(MIN_VAL);
    localparam logic [4:0] BLACK_VAL_V   = 5'(BLACK_VAL);

    logic colored;

    always_comb begin
        colored     = (value > MIN_VAL_V) && (saturation > MIN_SAT_S);
        pixel_class = VOID;
        // Out-of-range hue is never a color, even on a dark pixel.
        if (hue > 9'd359)
            pixel_class = VOID;
        else if (colored) begin
            if ((hue < RED_HIGH_H) || (hue > RED_LOW_H))
                pixel_class = RED;
            else if ((hue >= BLUE_LOW_H) && (hue <= BLUE_HIGH_H))
                pixel_class = BLUE;
            else if ((hue >= YELLOW_LOW_H) && (hue <= YELLOW_HIGH_H))
                pixel_class = YELLOW;
        end
        else if (value < BLACK_VAL_V)
            pixel_class = BLACK;
    end

endmodule

// File: rtl/ball_color_runs.sv
// Horizontal color run detector; define BALL_RUN_GAP_EN to bridge short BLACK gaps.
module ball_color_runs
    import ball_pkg::*;
#(
    parameter int HCOUNT_W    = 10,
    parameter int MIN_RUN     = 8,
    parameter int MAX_GAP     = 2,
    parameter int MIN_SAT     = DEF_MIN_SAT,
    parameter int MIN_VAL     = DEF_MIN_VAL,
    parameter int BLACK_VAL   = DEF_BLACK_VAL,
    parameter int RED_HIGH    = DEF_RED_HIGH,
    parameter int RED_LOW     = DEF_RED_LOW,
    parameter int BLUE_LOW    = DEF_BLUE_LOW,
    parameter int BLUE_HIGH   = DEF_BLUE_HIGH,
    parameter int YELLOW_LOW  = DEF_YELLOW_LOW,
    parameter int YELLOW_HIGH = DEF_YELLOW_HIGH
)(
    input  logic                clk,
    input  logic                reset,
    input  logic                write,
    input  logic [8:0]          hue,
    input  logic [4:0]          saturation,
    input  logic [4:0]          value,
    input  logic [HCOUNT_W-1:0] horiz_count,
    input  logic                line_start,
    output logic                run_valid,
    output logic [1:0]          run_color,
    output logic [HCOUNT_W-1:0] run_start,
    output logic [HCOUNT_W-1:0] run_end
);

    localparam logic [HCOUNT_W-1:0] MIN_RUN_W = HCOUNT_W'(MIN_RUN);
`ifdef BALL_RUN_GAP_EN
    localparam int GAP_W = (MAX_GAP < 1) ? 1 : $clog2(MAX_GAP + 1);
    localparam logic [GAP_W-1:0] MAX_GAP_G = GAP_W'(MAX_GAP);
    logic [GAP_W-1:0] gap_reg, gap_next;
`endif

    logic                s1_write_reg, s1_line_start_reg;
    logic [8:0]          s1_hue_reg;
    logic [4:0]          s1_sat_reg, s1_val_reg;
    logic [HCOUNT_W-1:0] s1_x_reg;
    color_class_e        pixel_class, s2_class_reg;
    logic                s2_write_reg, s2_line_start_reg;
    logic [HCOUNT_W-1:0] s2_x_reg;

    run_state_e          state_reg, state_next, cur_state;
    logic [1:0]          color_reg, color_next;
    logic [HCOUNT_W-1:0] start_reg, start_next, last_reg, last_next, run_len;
    color_class_e        eff_class;
    logic                is_color, same_color, start_run, close, emit;

    ball_pixel_class #(
        .MIN_SAT(MIN_SAT), .MIN_VAL(MIN_VAL), .BLACK_VAL(BLACK_VAL),
        .RED_HIGH(RED_HIGH), .RED_LOW(RED_LOW),
        .BLUE_LOW(BLUE_LOW), .BLUE_HIGH(BLUE_HIGH),
        .YELLOW_LOW(YELLOW_LOW), .YELLOW_HIGH(YELLOW_HIGH)
    ) u_class (
        .hue(s1_hue_reg),
        .saturation(s1_sat_reg),
        .value(s1_val_reg),
        .pixel_class(pixel_class)
    );

    always_comb begin
        eff_class = s2_class_reg;
`ifndef BALL_RUN_GAP_EN
        if (s2_class_reg == BLACK)
            eff_class = VOID;
`endif
        is_color   = (eff_class == RED) || (eff_class == BLUE) || (eff_class == YELLOW);
        same_color = is_color && (eff_class[1:0] == color_reg);
        // line_start closes the open run first; a coincident pixel then starts from IDLE.
        cur_state  = s2_line_start_reg ? ST_IDLE : state_reg;
        state_next = cur_state;
        color_next = color_reg;
        start_next = start_reg;
        last_next  = last_reg;
        close      = s2_line_start_reg && (state_reg != ST_IDLE);
        start_run  = 1'b0;
`ifdef BALL_RUN_GAP_EN
        gap_next   = gap_reg;
`endif
        if (s2_write_reg) begin
            case (cur_state)
                ST_IDLE: start_run = is_color;
                ST_RUN: begin
                    if (same_color)
                        last_next = s2_x_reg;
`ifdef BALL_RUN_GAP_EN
                    else if (eff_class == BLACK) begin
                        state_next = ST_GAP;
                        gap_next   = GAP_W'(1);
                    end
`endif
                    else begin
                        close      = 1'b1;
                        state_next = ST_IDLE;
                        start_run  = is_color;
                    end
                end
`ifdef BALL_RUN_GAP_EN
                ST_GAP: begin
                    if (eff_class == BLACK) begin
                        if (gap_reg < MAX_GAP_G)
                            gap_next = gap_reg + GAP_W'(1);
                        else begin
                            close      = 1'b1;
                            state_next = ST_IDLE;
                        end
                    end
                    else if (same_color) begin
                        state_next = ST_RUN;
                        last_next  = s2_x_reg;
                    end
                    else begin
                        close      = 1'b1;
                        state_next = ST_IDLE;
                        start_run  = is_color;
                    end
                end
`endif
                default: state_next = ST_IDLE;
            endcase
        end
        if (start_run) begin
            state_next = ST_RUN;
            color_next = eff_class[1:0];
            start_next = s2_x_reg;
            last_next  = s2_x_reg;
        end
        run_len = last_reg - start_reg + HCOUNT_W'(1);
        emit    = close && (run_len >= MIN_RUN_W);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_write_reg      <= 1'b0;
            s1_line_start_reg <= 1'b0;
            s1_hue_reg        <= '0;
            s1_sat_reg        <= '0;
            s1_val_reg        <= '0;
            s1_x_reg          <= '0;
            s2_write_reg      <= 1'b0;
            s2_line_start_reg <= 1'b0;
            s2_class_reg      <= VOID;
            s2_x_reg          <= '0;
            state_reg         <= ST_IDLE;
            color_reg         <= '0;
            start_reg         <= '0;
            last_reg          <= '0;
`ifdef BALL_RUN_GAP_EN
            gap_reg           <= '0;
`endif
            run_valid         <= 1'b0;
            run_color         <= '0;
            run_start         <= '0;
            run_end           <= '0;
        end else begin
            s1_write_reg      <= write;
            s1_line_start_reg <= line_start;
            s1_hue_reg        <= hue;
            s1_sat_reg        <= saturation;
            s1_val_reg        <= value;
            s1_x_reg          <= horiz_count;
            s2_write_reg      <= s1_write_reg;
            s2_line_start_reg <= s1_line_start_reg;
            s2_class_reg      <= pixel_class;
            s2_x_reg          <= s1_x_reg;
            state_reg         <= state_next;
            color_reg         <= color_next;
            start_reg         <= start_next;
            last_reg          <= last_next;
`ifdef BALL_RUN_GAP_EN
            gap_reg           <= gap_next;
`endif
            run_valid         <= emit;
            if (emit) begin
                run_color <= color_reg;
                run_start <= start_reg;
                run_end   <= last_reg;
            end
        end
    end

endmodule
